// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - funct codes, ALU op encodings and sequencer state type
package alu_ctrl_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_NAND = 6'h28;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [3:0] ALU_M_OR   = 4'b0000;
  localparam logic [3:0] ALU_M_AND  = 4'b0001;
  localparam logic [3:0] ALU_M_XOR  = 4'b0010;
  localparam logic [3:0] ALU_M_ADD  = 4'b0011;
  localparam logic [3:0] ALU_M_NOR  = 4'b0100;
  localparam logic [3:0] ALU_M_NAND = 4'b0101;
  localparam logic [3:0] ALU_M_SLT  = 4'b0110;
  localparam logic [3:0] ALU_M_SUB  = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/alu_funct_decoder.sv
// rtl/alu_funct_decoder.sv - combinational R-type funct to ALU op select decode
module alu_funct_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] m,
  output logic       illegal
);

  always_comb begin
    m       = ALU_M_OR;
    illegal = 1'b0;
    case (funct)
      FUNCT_ADD:  m = ALU_M_ADD;
      FUNCT_SUB:  m = ALU_M_SUB;
      FUNCT_AND:  m = ALU_M_AND;
      FUNCT_OR:   m = ALU_M_OR;
      FUNCT_XOR:  m = ALU_M_XOR;
      FUNCT_NOR:  m = ALU_M_NOR;
      FUNCT_NAND: m = ALU_M_NAND;
      FUNCT_SLT:  m = ALU_M_SLT;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer around a combinational ALU
// Optional status flags (rsp_zero, rsp_ovf) are enabled by ALU_STATUS_FLAGS_EN.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_m,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_ovf
`endif
);

  localparam int CNT_W = 4;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_m;
  logic             dec_illegal;
  logic             sample;

  alu_funct_decoder u_dec (
    .funct   (req_funct),
    .m       (dec_m),
    .illegal (dec_illegal)
  );

  assign sample = (state == EXEC) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = dec_illegal ? RESP : EXEC;
      end
      EXEC: if (sample) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_STATUS_FLAGS_EN
  // Signed overflow from the latched operand signs and the sampled result sign.
  logic sa, sb, sr, ovf_now;
  assign sa = alu_a[WIDTH-1];
  assign sb = alu_b[WIDTH-1];
  assign sr = alu_result[WIDTH-1];
  always_comb begin
    ovf_now = 1'b0;
    if (alu_m == ALU_M_ADD)      ovf_now = (sa == sb) && (sr != sa);
    else if (alu_m == ALU_M_SUB) ovf_now = (sa != sb) && (sr != sa);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_m    <= 4'b0000;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dec_illegal) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
              rsp_zero <= 1'b1;
              rsp_ovf  <= 1'b0;
`endif
            end else begin
              alu_a <= req_a;
              alu_b <= req_b;
              alu_m <= dec_m;
              cnt   <= CNT_W'(ALU_LAT);
            end
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (sample) begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            rsp_zero <= (alu_result == '0);
            rsp_ovf  <= ovf_now;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer, ALU_LAT 1 and 4 instances
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [5:0]  req_funct [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [3:0]  alu_m     [2];
  logic [31:0] alu_result[2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
`ifdef ALU_STATUS_FLAGS_EN
  logic        rsp_zero  [2];
  logic        rsp_ovf   [2];
`endif

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(32), .ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_funct(req_funct[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_m(alu_m[0]), .alu_result(alu_result[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
`ifdef ALU_STATUS_FLAGS_EN
    , .rsp_zero(rsp_zero[0]), .rsp_ovf(rsp_ovf[0])
`endif
  );

  alu_op_sequencer #(.WIDTH(32), .ALU_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_funct(req_funct[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_m(alu_m[1]), .alu_result(alu_result[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
`ifdef ALU_STATUS_FLAGS_EN
    , .rsp_zero(rsp_zero[1]), .rsp_ovf(rsp_ovf[1])
`endif
  );

  // Combinational ALU the sequencer drives, keyed on the op select encoding.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    case (m)
      4'b0011: return a + b;
      4'b0111: return a - b;
      4'b0001: return a & b;
      4'b0000: return a | b;
      4'b0010: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0101: return ~(a & b);
      4'b0110: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result[0] = alu_f(alu_a[0], alu_b[0], alu_m[0]);
  always_comb alu_result[1] = alu_f(alu_a[1], alu_b[1], alu_m[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, deassert after accept, wait for the response and check it.
  task automatic op(input int i, input string tag, input logic [5:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_data, input logic exp_err,
                    input logic [3:0] exp_m, input int exp_lat, input logic exp_ovf);
    int n;
    req_funct[i] = f; req_a[i] = a; req_b[i] = b; req_valid[i] = 1'b1;
    check({tag, " ready"}, req_ready[i], 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 40);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " data"}, rsp_data[i], exp_data);
    check({tag, " err"}, rsp_err[i], exp_err);
    check({tag, " alu_m"}, alu_m[i], exp_m);
    check({tag, " busy"}, req_ready[i], 0);
`ifdef ALU_STATUS_FLAGS_EN
    check({tag, " zero"}, rsp_zero[i], exp_data == 0);
    check({tag, " ovf"}, rsp_ovf[i], exp_ovf);
`else
    if (exp_ovf) n = n;
`endif
    @(negedge clk);
    check({tag, " done"}, rsp_valid[i], 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_funct[i] = 6'h0; req_a[i] = '0; req_b[i] = '0; rsp_ready[i] = 1'b1;
    end
    #12;
    check("reset ready", req_ready[0], 1);
    check("reset rsp_valid", rsp_valid[0], 0);
    check("reset rsp_data", rsp_data[0], 0);
    check("reset alu_m", alu_m[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an ALU_LAT=4 operation: the op must vanish.
    req_funct[1] = 6'h20; req_a[1] = 32'h55; req_b[1] = 32'h66; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("midexec alu_a", alu_a[1], 32'h55);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst ready", req_ready[1], 1);
    check("rst alu_a", alu_a[1], 0);
    check("rst alu_b", alu_b[1], 0);
    check("rst alu_m", alu_m[1], 0);
    check("rst data", rsp_data[1], 0);
    check("rst err", rsp_err[1], 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) n++;
    end
    check("rst no rsp", n, 0);

    // Directed ops on the ALU_LAT=1 instance.
    op(0, "add_ovf", 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 4'b0011, 2, 1'b1);
    op(0, "sub_zero", 6'h22, 32'h5, 32'h5, 32'h0, 1'b0, 4'b0111, 2, 1'b0);
    op(0, "slt_neg", 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 4'b0110, 2, 1'b0);
    op(0, "illegal", 6'h3F, 32'h1234, 32'h5678, 32'h0, 1'b1, 4'b0110, 1, 1'b0);

    // Backpressure: response held for 10 cycles while a new request waits.
    rsp_ready[0] = 1'b0;
    req_funct[0] = 6'h20; req_a[0] = 32'd3; req_b[0] = 32'd4; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("bp valid", rsp_valid[0], 1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd7 || req_ready[0] !== 1'b0) n++;
    end
    check("bp stall stable", n, 0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp released", req_ready[0], 1);
    req_a[0] = 32'd10; req_b[0] = 32'd20;
    @(negedge clk);
    check("bp second accepted", req_ready[0], 0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp second valid", rsp_valid[0], 1);
    check("bp second data", rsp_data[0], 32'd30);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid[0] || !req_ready[0]) n++;
    end
    check("bp single accept", n, 0);

    // All eight legal functs back-to-back on both latencies.
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 2 : 5;
      op(i, "b2b add",  6'h20, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 1'b0, 4'b0011, lat, 1'b0);
      op(i, "b2b sub",  6'h22, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0325_4769, 1'b0, 4'b0111, lat, 1'b0);
      op(i, "b2b and",  6'h24, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 4'b0001, lat, 1'b0);
      op(i, "b2b or",   6'h25, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F, 1'b0, 4'b0000, lat, 1'b0);
      op(i, "b2b xor",  6'h26, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 1'b0, 4'b0010, lat, 1'b0);
      op(i, "b2b nor",  6'h27, 32'h1234_5678, 32'h0F0F_0F0F, 32'hE0C0_A080, 1'b0, 4'b0100, lat, 1'b0);
      op(i, "b2b nand", 6'h28, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFDFB_F9F7, 1'b0, 4'b0101, lat, 1'b0);
      op(i, "b2b slt",  6'h2A, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 4'b0110, lat, 1'b0);
    end
    op(1, "sub_ovf4", 6'h22, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 4'b0111, 5, 1'b1);
    op(1, "illegal4", 6'h00, 32'h1, 32'h1, 32'h0, 1'b1, 4'b0111, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
